// File: rtl/pwls_output_mixer.sv
// rtl/pwls_output_mixer.sv - per-frame channel mixer with saturating master shift and delta-sigma output
// Sums one sample per channel per frame, flags duplicate/missing channels, and drives a 1-bit modulator.
module pwls_output_mixer #(
   parameter int BITS         = 12,
   parameter int NUM_CHANNELS = 4,
   parameter int CH_BITS      = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [BITS-1:0]     sample_in,
   input  logic                sample_valid,
   input  logic [CH_BITS-1:0]  sample_channel,
   input  logic                sample_last,
   input  logic [CH_BITS:0]    master_shift,
   output logic [BITS-1:0]     out_sample,
   output logic                frame_strobe,
   output logic                pdm_out,
   output logic                overrun,
   output logic                underrun,
   input  logic                clear_flags
);

   localparam int AW = BITS + CH_BITS;
   localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (BITS - 1)) - 1);
   localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

   logic signed [AW-1:0]       acc;
   logic [NUM_CHANNELS-1:0]    rx;
   logic [BITS-1:0]            ds;

   logic [NUM_CHANNELS-1:0]    ch_bit;
   logic [NUM_CHANNELS-1:0]    rx_all;
   logic                       dup;
   logic                       accept;
   logic                       commit;
   logic signed [AW-1:0]       sample_ext;
   logic signed [AW-1:0]       acc_next;
   logic [CH_BITS:0]           sh_eff;
   logic signed [AW-1:0]       scaled;
   logic signed [AW-1:0]       sat;
   logic [BITS:0]              ds_sum;

   always_comb begin
      ch_bit     = NUM_CHANNELS'(1) << sample_channel;
      rx_all     = rx | ch_bit;
      dup        = rx[sample_channel];
      accept     = sample_valid & ~dup;
      commit     = sample_valid & sample_last;
      sample_ext = {{CH_BITS{sample_in[BITS-1]}}, sample_in};
      acc_next   = accept ? (acc + sample_ext) : acc;
      sh_eff     = (master_shift > (CH_BITS+1)'(CH_BITS)) ? (CH_BITS+1)'(CH_BITS) : master_shift;
      scaled     = acc_next >>> sh_eff;
      if (scaled > SAT_HI) begin
         sat = SAT_HI;
      end else if (scaled < SAT_LO) begin
         sat = SAT_LO;
      end else begin
         sat = scaled;
      end
      // Offset-binary view of the held sample: flipping the sign bit maps -2^(BITS-1) to 0.
      ds_sum = {1'b0, ds} + {1'b0, ~out_sample[BITS-1], out_sample[BITS-2:0]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc          <= '0;
         rx           <= '0;
         ds           <= '0;
         out_sample   <= '0;
         frame_strobe <= 1'b0;
         pdm_out      <= 1'b0;
         overrun      <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         frame_strobe <= commit;
         if (commit) begin
            out_sample <= sat[BITS-1:0];
            acc        <= '0;
            rx         <= '0;
         end else if (accept) begin
            acc <= acc_next;
            rx  <= rx_all;
         end

         if (sample_valid && dup) begin
            overrun <= 1'b1;
         end else if (clear_flags) begin
            overrun <= 1'b0;
         end

         if (commit && !(&rx_all)) begin
            underrun <= 1'b1;
         end else if (clear_flags) begin
            underrun <= 1'b0;
         end

         ds      <= ds_sum[BITS-1:0];
         pdm_out <= ds_sum[BITS];
      end
   end

endmodule

// File: tb/tb_pwls_output_mixer.sv
// tb/tb_pwls_output_mixer.sv - directed vector bench for pwls_output_mixer
// Table of single-beat vectors plus hand sequences for modulator and mid-frame reset.
module tb_pwls_output_mixer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] sample_in;
   logic        sample_valid;
   logic [1:0]  sample_channel;
   logic        sample_last;
   logic [2:0]  master_shift;
   logic [11:0] out_sample;
   logic        frame_strobe;
   logic        pdm_out;
   logic        overrun;
   logic        underrun;
   logic        clear_flags;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       v;
      logic [1:0] ch;
      logic       l;
      int         s;
      logic [2:0] sh;
      logic       clr;
      int         eo;
      logic       es;
      logic       eov;
      logic       eun;
   } vec_t;

   vec_t vecs[$];

   pwls_output_mixer #(.BITS(12), .NUM_CHANNELS(4), .CH_BITS(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sample_in      (sample_in),
      .sample_valid   (sample_valid),
      .sample_channel (sample_channel),
      .sample_last    (sample_last),
      .master_shift   (master_shift),
      .out_sample     (out_sample),
      .frame_strobe   (frame_strobe),
      .pdm_out        (pdm_out),
      .overrun        (overrun),
      .underrun       (underrun),
      .clear_flags    (clear_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic v, input logic [1:0] ch, input logic l, input int s,
                               input logic [2:0] sh, input logic clr, input int eo,
                               input logic es, input logic eov, input logic eun);
      vec_t t;
      t.v = v; t.ch = ch; t.l = l; t.s = s; t.sh = sh; t.clr = clr;
      t.eo = eo; t.es = es; t.eov = eov; t.eun = eun;
      vecs.push_back(t);
   endfunction

   task automatic beat(input logic v, input logic [1:0] ch, input logic l, input int s);
      @(negedge clk);
      sample_valid   = v;
      sample_channel = ch;
      sample_last    = l;
      sample_in      = 12'(s);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ones;
      rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; sample_channel = '0;
      sample_last = 1'b0; master_shift = '0; clear_flags = 1'b0;

      // Frames: basic sum, saturation, shift clamp, duplicate, missing, flag priority.
      add(1,0,0, 100,0,0,    0,0,0,0);
      add(1,1,0, 200,0,0,    0,0,0,0);
      add(1,2,0, -50,0,0,    0,0,0,0);
      add(1,3,1,   0,0,0,  250,1,0,0);
      add(0,0,1,   0,0,0,  250,0,0,0);
      for (int k = 0; k < 4; k++) add(1,2'(k),k==3, 2047,0,0, k==3 ? 2047 : 250, k==3,0,0);
      for (int k = 0; k < 4; k++) add(1,2'(k),k==3, 2047,2,0, 2047, k==3,0,0);
      for (int k = 0; k < 4; k++) add(1,2'(k),k==3,-2048,0,0, k==3 ? -2048 : 2047, k==3,0,0);
      for (int k = 0; k < 4; k++) add(1,2'(k),k==3,(k+1)*100,1,0, k==3 ? 500 : -2048, k==3,0,0);
      for (int k = 0; k < 4; k++) add(1,2'(k),k==3,(k+1)*100,5,0, k==3 ? 250 : 500, k==3,0,0);
      add(1,0,0,  10,0,0,  250,0,0,0);
      add(1,0,0,  20,0,0,  250,0,1,0);
      add(1,1,0,   1,0,0,  250,0,1,0);
      add(1,2,0,   1,0,0,  250,0,1,0);
      add(1,3,1,   1,0,0,   13,1,1,0);
      add(0,0,0,   0,0,1,   13,0,0,0);
      add(1,0,0,   5,0,0,   13,0,0,0);
      add(1,2,1,   5,0,0,   10,1,0,1);
      for (int k = 0; k < 4; k++) add(1,2'(k),k==3, 1,0,0, k==3 ? 4 : 10, k==3,0,1);
      add(0,0,0,   0,0,1,    4,0,0,0);
      add(1,1,0,   7,0,0,    4,0,0,0);
      add(1,1,0,   7,0,1,    4,0,1,0);
      add(1,0,1,  -7,0,0,    0,1,1,1);
      add(0,0,0,   0,0,1,    0,0,0,0);

      repeat (2) @(posedge clk);
      #1;
      check("rst_out", int'($signed(out_sample)), 0);
      check("rst_strobe", int'(frame_strobe), 0);
      check("rst_pdm", int'(pdm_out), 0);
      check("rst_ovr", int'(overrun), 0);
      check("rst_unr", int'(underrun), 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         sample_valid   = vecs[i].v;
         sample_channel = vecs[i].ch;
         sample_last    = vecs[i].l;
         sample_in      = 12'(vecs[i].s);
         master_shift   = vecs[i].sh;
         clear_flags    = vecs[i].clr;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_out", i), int'($signed(out_sample)), vecs[i].eo);
         check($sformatf("v%0d_strobe", i), int'(frame_strobe), int'(vecs[i].es));
         check($sformatf("v%0d_ovr", i), int'(overrun), int'(vecs[i].eov));
         check($sformatf("v%0d_unr", i), int'(underrun), int'(vecs[i].eun));
      end
      @(negedge clk);
      sample_valid = 1'b0; sample_last = 1'b0; clear_flags = 1'b0; master_shift = '0;

      // Modulator from reset: midscale alternates starting with 0.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("pdm_mid%0d", k), int'(pdm_out), k % 2);
      end

      for (int k = 0; k < 4; k++) beat(1, 2'(k), k == 3, 2047);
      beat(0, 0, 0, 0);
      beat(0, 0, 0, 0);
      ones = 0;
      for (int k = 0; k < 64; k++) begin
         @(posedge clk);
         #1;
         ones += int'(pdm_out);
      end
      check("pdm_full_min63", int'(ones >= 63), 1);

      for (int k = 0; k < 4; k++) beat(1, 2'(k), k == 3, -2048);
      beat(0, 0, 0, 0);
      beat(0, 0, 0, 0);
      ones = 0;
      for (int k = 0; k < 32; k++) begin
         @(posedge clk);
         #1;
         ones += int'(pdm_out);
      end
      check("pdm_zero_ones", ones, 0);

      // Reset mid-frame discards the partial sum and the sticky flag.
      beat(1, 0, 0, 500);
      beat(1, 1, 0, 500);
      beat(1, 1, 0, 500);
      check("mid_ovr_set", int'(overrun), 1);
      @(negedge clk);
      rst_n = 1'b0;
      sample_valid = 1'b1; sample_channel = 2; sample_in = 12'd500; sample_last = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_out", int'($signed(out_sample)), 0);
      check("mid_rst_ovr", int'(overrun), 0);
      check("mid_rst_strobe", int'(frame_strobe), 0);
      @(negedge clk);
      rst_n = 1'b1;
      sample_valid = 1'b0; sample_last = 1'b0;
      for (int k = 0; k < 4; k++) beat(1, 2'(k), k == 3, 1);
      check("mid_out", int'($signed(out_sample)), 4);
      check("mid_strobe", int'(frame_strobe), 1);
      check("mid_ovr", int'(overrun), 0);
      check("mid_unr", int'(underrun), 0);
      beat(0, 0, 0, 0);
      check("mid_strobe_low", int'(frame_strobe), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwls_output_mixer.md
# pwls_output_mixer

Downstream stage of the per-channel ALU unit: collects one signed sample per channel per frame from the time-multiplexed channel pipeline, sums them, applies a master shift with saturation, and latches the frame result. The latched sample drives a first-order delta-sigma modulator whose 1-bit output feeds the synth's audio pin. Duplicate-channel errors and missing-channel errors are reported on sticky flags.

## Interface
- BITS, 12, channel sample width (signed two's complement) and output sample width
- NUM_CHANNELS, 4, channels summed per frame (power of two)
- CH_BITS, 2, log2(NUM_CHANNELS)
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- sample_in  in  BITS  signed channel sample from the channel ALU unit
- sample_valid  in  1  sample_in/sample_channel/sample_last valid this cycle
- sample_channel  in  CH_BITS  channel index of sample_in
- sample_last  in  1  final sample of the current frame; commits the frame
- master_shift  in  CH_BITS+1  arithmetic right shift applied to frame sum, 0..CH_BITS; larger values clamp to CH_BITS
- out_sample  out  BITS  signed mixed sample of last committed frame
- frame_strobe  out  1  one-cycle pulse when out_sample updates
- pdm_out  out  1  delta-sigma bitstream, one bit per clk
- overrun  out  1  sticky: a channel delivered twice within one frame
- underrun  out  1  sticky: a frame committed with a channel missing
- clear_flags  in  1  clears overrun and underrun

## Operation
- Frame accumulator acc: signed, BITS+CH_BITS wide; received mask rx: NUM_CHANNELS bits.
- Accept: sample_valid=1 and rx[sample_channel]=0 -> acc += sign-extended sample_in, rx[sample_channel] set.
- Duplicate: sample_valid=1 and rx[sample_channel]=1 -> sample discarded, overrun set; sample_last on that beat still commits.
- Commit (sample_valid=1, sample_last=1): total = acc + accepted sample (if accepted); scaled = total >>> min(master_shift, CH_BITS); out_sample <= saturate to [-2^(BITS-1), 2^(BITS-1)-1]; acc <= 0, rx <= 0; underrun set if any rx bit (including this beat) was 0.
- sample_last with sample_valid=0 is ignored.
- Flags: clear_flags has priority below setting in the same cycle (set wins).
- Delta-sigma: u = out_sample with MSB inverted (offset binary, BITS unsigned); each clk {c, ds} <= ds + u, ds BITS wide; pdm_out <= c.
- Modulator runs every cycle independent of frames; uses current out_sample register value.

## Timing
- Reset values: out_sample=0, frame_strobe=0, pdm_out=0, overrun=0, underrun=0, acc=0, rx=0, ds=0.
- Accept latency: sample counted at the clk edge where sample_valid=1; no back-pressure, always ready.
- Commit beat at edge N: out_sample and frame_strobe=1 visible after edge N; frame_strobe low after edge N+1 unless another commit.
- Back-to-back frames: a sample_valid beat directly after a commit starts the new frame with acc=0.
- pdm_out reflects the out_sample value present before the edge, i.e. new out_sample affects pdm_out from edge N+1 onward.
- rst_n low mid-frame: partial frame discarded, all state to reset values at that edge; inputs ignored while rst_n=0.

## Test plan
- BITS=12, 4 channels, shift 0: ch0..3 = 100, 200, -50, 0 (last on ch3) -> out_sample=250, frame_strobe one cycle, no flags.
- Saturation: four 2047 with shift 0 -> out_sample=2047; same with shift 2 -> 2047 (8188>>>2); four -2048 shift 0 -> -2048; shift 5 treated as 2.
- Duplicate: ch0=10, ch0=20, ch1=1, ch2=1, ch3=1 last -> out_sample=13, overrun=1, underrun=0; clear_flags -> overrun=0.
- Missing: ch0=5, ch2=5 last -> out_sample=10, underrun=1; next full frame leaves underrun sticky until clear_flags.
- PDM: out_sample=0 from reset state -> pdm_out 0,1,0,1,...; out_sample=2047 -> ones density 4095/4096; out_sample=-2048 -> all zeros.
- Reset mid-frame: ch0=500, ch1=500, rst_n low one cycle, then ch0..3 = 1 last -> out_sample=4, no flags.
